// File: rtl/radiation_histogram_if.sv
// Sample stream, PS bin readout and summary counter signals of the radiation histogram.
// The slave modport is the histogram side; the master modport is the processor/PS side.
interface radiation_histogram_if #(
    parameter int unsigned VALUE_WIDTH    = 16,
    parameter int unsigned BIN_ADDR_WIDTH = 6,
    parameter int unsigned COUNT_WIDTH    = 32
);
    logic                      sampleValid;
    logic [VALUE_WIDTH-1:0]    radiationValue;
    logic                      sampleReady;
    logic                      valueProcessingFinished;
    logic [VALUE_WIDTH-1:0]    minValue;
    logic [3:0]                binShift;
    logic                      clearStart;
    logic                      clearBusy;
    logic [BIN_ADDR_WIDTH-1:0] readAddress;
    logic                      readRequest;
    logic [COUNT_WIDTH-1:0]    readData;
    logic                      readDataValid;
    logic [COUNT_WIDTH-1:0]    totalCount;
    logic [COUNT_WIDTH-1:0]    underflowCount;
    logic [COUNT_WIDTH-1:0]    overflowCount;
    logic [COUNT_WIDTH-1:0]    droppedCount;

    modport slave (
        input  sampleValid, radiationValue, minValue, binShift, clearStart,
               readAddress, readRequest,
        output sampleReady, valueProcessingFinished, clearBusy, readData, readDataValid,
               totalCount, underflowCount, overflowCount, droppedCount
    );

    modport master (
        output sampleValid, radiationValue, minValue, binShift, clearStart,
               readAddress, readRequest,
        input  sampleReady, valueProcessingFinished, clearBusy, readData, readDataValid,
               totalCount, underflowCount, overflowCount, droppedCount
    );
endinterface

// File: rtl/radiation_histogram.sv
// Histogram binning of the radiation sample stream via a forwarded read-modify-write pipeline,
// with a clear sweep, PS bin readout on the shared read port and summary counters.
module radiation_histogram #(
    parameter int unsigned VALUE_WIDTH    = 16,
    parameter int unsigned BIN_ADDR_WIDTH = 6,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input logic                  clk,
    input logic                  S_AXI_ARESETN,
    radiation_histogram_if.slave bus
);
    localparam int unsigned NumBins = 2 ** BIN_ADDR_WIDTH;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                    state_q;
    logic                      ready_q, busy_q;
    logic [BIN_ADDR_WIDTH-1:0] clr_addr_q;

    logic                      s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q, s2_ps_q;
    logic [BIN_ADDR_WIDTH-1:0] s1_idx_q, s2_idx_q, s3_idx_q, s4_idx_q;
    logic [COUNT_WIDTH-1:0]    s3_count_q, s4_count_q, rd_data_q;
    logic                      d1_q, d2_q, d3_q;

    logic                      pend_q;
    logic [BIN_ADDR_WIDTH-1:0] pend_addr_q;
    logic [COUNT_WIDTH-1:0]    read_data_q;
    logic                      read_valid_q;
    logic [COUNT_WIDTH-1:0]    total_q, under_q, over_q, dropped_q;

    logic [COUNT_WIDTH-1:0]    mem [NumBins];

    logic [VALUE_WIDTH:0]      diff;
    logic [VALUE_WIDTH-1:0]    shifted;
    logic                      underflow, overflow, accept, ps_service, mem_we;
    logic [BIN_ADDR_WIDTH-1:0] rd_addr;
    logic [COUNT_WIDTH-1:0]    fwd_count, new_count;

    always_comb begin
        diff       = {1'b0, bus.radiationValue} - {1'b0, bus.minValue};
        shifted    = diff[VALUE_WIDTH-1:0] >> bus.binShift;
        underflow  = diff[VALUE_WIDTH];
        overflow   = |shifted[VALUE_WIDTH-1:BIN_ADDR_WIDTH];
        accept     = bus.sampleValid && (state_q == StIdle) && !bus.clearStart;
        ps_service = pend_q && !s1_valid_q && (state_q == StIdle);
        rd_addr    = s1_valid_q ? s1_idx_q : pend_addr_q;
        mem_we     = s3_valid_q && (state_q == StIdle);
        // s3 is newer than s4, so it takes priority; both cover writes not yet visible to the read
        fwd_count  = rd_data_q;
        if (s4_valid_q && (s4_idx_q == s2_idx_q)) fwd_count = s4_count_q;
        if (s3_valid_q && (s3_idx_q == s2_idx_q)) fwd_count = s3_count_q;
        new_count  = (&fwd_count) ? fwd_count : fwd_count + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_addr_q] <= '0;
        end else if (s3_valid_q) begin
            mem[s3_idx_q] <= s3_count_q;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= StIdle;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            clr_addr_q   <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            s4_valid_q   <= 1'b0;
            s2_ps_q      <= 1'b0;
            s1_idx_q     <= '0;
            s2_idx_q     <= '0;
            s3_idx_q     <= '0;
            s4_idx_q     <= '0;
            s3_count_q   <= '0;
            s4_count_q   <= '0;
            d1_q         <= 1'b0;
            d2_q         <= 1'b0;
            d3_q         <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            total_q      <= '0;
            under_q      <= '0;
            over_q       <= '0;
            dropped_q    <= '0;
        end else begin
            s1_valid_q   <= accept && !underflow && !overflow;
            s1_idx_q     <= shifted[BIN_ADDR_WIDTH-1:0];
            s2_valid_q   <= s1_valid_q;
            s2_ps_q      <= ps_service;
            s2_idx_q     <= rd_addr;
            s3_valid_q   <= s2_valid_q;
            s3_idx_q     <= s2_idx_q;
            s3_count_q   <= new_count;
            s4_valid_q   <= mem_we;
            s4_idx_q     <= s3_idx_q;
            s4_count_q   <= s3_count_q;
            // completion flag rides alongside every accepted sample, binned or not
            d1_q         <= accept;
            d2_q         <= d1_q;
            d3_q         <= d2_q;
            read_valid_q <= s2_ps_q;
            if (s2_ps_q) read_data_q <= fwd_count;

            if (bus.readRequest) begin
                pend_q      <= 1'b1;
                pend_addr_q <= bus.readAddress;
            end else if (ps_service) begin
                pend_q <= 1'b0;
            end

            if (bus.clearStart) begin
                state_q    <= StClear;
                busy_q     <= 1'b1;
                ready_q    <= 1'b0;
                clr_addr_q <= '0;
                total_q    <= '0;
                under_q    <= '0;
                over_q     <= '0;
                // clear wins over a coincident sample, which still counts as dropped
                dropped_q  <= COUNT_WIDTH'(bus.sampleValid);
            end else begin
                if (state_q == StClear) begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == '1) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                total_q   <= total_q + COUNT_WIDTH'(accept);
                under_q   <= under_q + COUNT_WIDTH'(accept && underflow);
                over_q    <= over_q + COUNT_WIDTH'(accept && !underflow && overflow);
                dropped_q <= dropped_q + COUNT_WIDTH'(bus.sampleValid && !accept);
            end
        end
    end

    assign bus.sampleReady             = ready_q;
    assign bus.clearBusy               = busy_q;
    assign bus.valueProcessingFinished = d3_q;
    assign bus.readData                = read_data_q;
    assign bus.readDataValid           = read_valid_q;
    assign bus.totalCount              = total_q;
    assign bus.underflowCount          = under_q;
    assign bus.overflowCount           = over_q;
    assign bus.droppedCount            = dropped_q;
endmodule

// File: tb/tb_radiation_histogram.sv
// Scoreboard bench for radiation_histogram: completion pulses and readouts are queued on issue
// and matched by a negedge monitor; a 4-bit-count instance exercises saturation and wrap.
module tb_radiation_histogram;
    localparam int unsigned VW = 16;
    localparam int unsigned BAW = 6;
    localparam int unsigned CW = 32;

    typedef struct {
        logic [CW-1:0] data;
        int            cyc;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errs = 0;
    int   vpf_q[$];
    rd_exp_t rd_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    radiation_histogram_if #(.VALUE_WIDTH(VW), .BIN_ADDR_WIDTH(BAW), .COUNT_WIDTH(CW)) hb ();
    radiation_histogram_if #(.VALUE_WIDTH(VW), .BIN_ADDR_WIDTH(BAW), .COUNT_WIDTH(4)) sb ();

    radiation_histogram #(.VALUE_WIDTH(VW), .BIN_ADDR_WIDTH(BAW), .COUNT_WIDTH(CW)) u_dut (
        .clk(clk), .S_AXI_ARESETN(rst_n), .bus(hb.slave)
    );
    radiation_histogram #(.VALUE_WIDTH(VW), .BIN_ADDR_WIDTH(BAW), .COUNT_WIDTH(4)) u_sat (
        .clk(clk), .S_AXI_ARESETN(rst_n), .bus(sb.slave)
    );

    function automatic void chk(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (hb.valueProcessingFinished) begin
            if (vpf_q.size() == 0) chk("vpf_unexpected", 1, 0);
            else chk("vpf_cycle", cyc, vpf_q.pop_front());
        end
        if (hb.readDataValid) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", hb.readData, e.data);
                chk("rd_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [VW-1:0] v);
        hb.sampleValid    = 1'b1;
        hb.radiationValue = v;
        vpf_q.push_back(cyc + 3);
        tick();
        hb.sampleValid = 1'b0;
    endtask

    task automatic read_req(input int a, input logic [CW-1:0] exp, input int lat);
        rd_exp_t e;
        hb.readRequest = 1'b1;
        hb.readAddress = BAW'(a);
        e.data = exp;
        e.cyc  = cyc + lat;
        rd_q.push_back(e);
        tick();
        hb.readRequest = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((vpf_q.size() != 0 || rd_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", vpf_q.size() + rd_q.size(), 0);
    endtask

    task automatic chk_counters(string tag, int t, int u, int o, int d);
        chk({tag, "_total"}, hb.totalCount, t);
        chk({tag, "_under"}, hb.underflowCount, u);
        chk({tag, "_over"}, hb.overflowCount, o);
        chk({tag, "_dropped"}, hb.droppedCount, d);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n_busy;
        int c;
        int n;
        logic [3:0] sat_data;
        logic       sat_seen;
        hb.sampleValid = 0; hb.radiationValue = '0; hb.minValue = '0; hb.binShift = '0;
        hb.clearStart = 0; hb.readAddress = '0; hb.readRequest = 0;
        sb.sampleValid = 0; sb.radiationValue = '0; sb.minValue = '0; sb.binShift = '0;
        sb.clearStart = 0; sb.readAddress = '0; sb.readRequest = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_sample_ready", hb.sampleReady, 1);
        chk("rst_clear_busy", hb.clearBusy, 0);
        chk("rst_vpf", hb.valueProcessingFinished, 0);
        chk("rst_read_valid", hb.readDataValid, 0);
        chk("rst_read_data", hb.readData, 0);
        chk_counters("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Clear sweep: busy for exactly 64 cycles, all bins zero afterwards
        hb.clearStart = 1; sb.clearStart = 1;
        tick();
        hb.clearStart = 0; sb.clearStart = 0;
        chk("clear_ready_low", hb.sampleReady, 0);
        n_busy = 0;
        repeat (70) begin
            if (hb.clearBusy) n_busy++;
            tick();
        end
        chk("clear_busy_cycles", n_busy, 64);
        chk("clear_ready_back", hb.sampleReady, 1);
        chk_counters("clr1", 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) read_req(i, 0, 3);
        wait_drain();

        // Basic binning: min 100, width 16
        hb.minValue = 16'd100; hb.binShift = 4'd4;
        send(16'd100); repeat (4) tick();
        send(16'd115); repeat (4) tick();
        send(16'd116); repeat (4) tick();
        send(16'd1123); repeat (4) tick();
        wait_drain();
        read_req(0, 2, 3); read_req(1, 1, 3); read_req(63, 1, 3); read_req(2, 0, 3);
        wait_drain();
        chk_counters("bin", 4, 0, 0, 0);

        // Underflow and overflow leave bins alone
        send(16'd99); repeat (4) tick();
        send(16'd1124); repeat (4) tick();
        wait_drain();
        read_req(0, 2, 3); read_req(63, 1, 3);
        wait_drain();
        chk_counters("range", 6, 1, 1, 0);

        // Forwarding: consecutive and 2-cycle-spaced hits on one bin
        hb.minValue = '0; hb.binShift = '0;
        for (int i = 0; i < 10; i++) send(16'd7);
        send(16'd9); tick(); send(16'd9); tick(); send(16'd9);
        wait_drain();
        read_req(7, 10, 3); read_req(9, 3, 3);
        wait_drain();

        // Readout colliding with a sample to the same bin: serviced after it, post-update value
        hb.sampleValid = 1; hb.radiationValue = 16'd7;
        hb.readRequest = 1; hb.readAddress = 6'd7;
        vpf_q.push_back(cyc + 3);
        rd_q.push_back('{data: 32'd11, cyc: cyc + 4});
        tick();
        hb.sampleValid = 0; hb.readRequest = 0;
        wait_drain();
        read_req(7, 11, 3);
        wait_drain();
        chk_counters("pre_clr2", 20, 1, 1, 0);

        // Clear mid-burst with a coincident sample; readout requested during the sweep
        send(16'd20); send(16'd20); send(16'd20);
        c = cyc;
        hb.clearStart = 1; hb.sampleValid = 1; hb.radiationValue = 16'd20;
        tick();
        hb.clearStart = 0; hb.sampleValid = 0;
        repeat (9) tick();
        read_req(20, 0, 57);
        n = 0;
        while (hb.clearBusy && n < 100) begin
            tick();
            n++;
        end
        chk("clr2_done", hb.clearBusy, 0);
        chk("clr2_idle_cycle", cyc, c + 65);
        wait_drain();
        chk_counters("clr2", 0, 0, 0, 1);
        for (int i = 0; i < 64; i++) read_req(i, 0, 3);
        wait_drain();

        // 4-bit counts: 20 hits saturate the bin at 15, totalCount wraps to 20 mod 16
        sb.minValue = '0; sb.binShift = '0;
        sb.sampleValid = 1; sb.radiationValue = 16'd5;
        repeat (20) tick();
        sb.sampleValid = 0;
        repeat (6) tick();
        sb.readRequest = 1; sb.readAddress = 6'd5;
        tick();
        sb.readRequest = 0;
        sat_seen = 0; sat_data = '0;
        n = 0;
        while (!sat_seen && n < 10) begin
            if (sb.readDataValid) begin
                sat_seen = 1;
                sat_data = sb.readData;
            end else begin
                tick();
            end
            n++;
        end
        chk("sat_read_seen", sat_seen, 1);
        chk("sat_bin5", sat_data, 15);
        chk("sat_total_wrap", sb.totalCount, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
